// File: rtl/cpu_int_ctrl.sv
// Interrupt controller for the CPU: frame, line and external interrupt sources,
// prioritised onto a single active-low INT with an IM2 vector on acknowledge.
package cpu_int_ctrl_pkg;
    typedef enum logic [1:0] {
        S48  = 2'd0,
        S128 = 2'd1,
        PENT = 2'd2
    } timings_t;
endpackage

module cpu_int_ctrl
    import cpu_int_ctrl_pkg::*;
#(
    parameter int unsigned NEXT       = 2,
    parameter int unsigned INT_LEN    = 32,
    parameter logic [7:0]  VEC_BASE   = 8'hE0,
    parameter int unsigned INT_V_S48  = 247,
    parameter int unsigned INT_H_S48  = 442,
    parameter int unsigned INT_V_S128 = 247,
    parameter int unsigned INT_H_S128 = 450,
    parameter int unsigned INT_V_PENT = 239,
    parameter int unsigned INT_H_PENT = 316
) (
    input  logic              rst_n,
    input  logic              clkcpu,
    input  logic [8:0]        vc,
    input  logic [8:0]        hc,
    input  timings_t          timings,
    input  logic [8:0]        line_vc,
    input  logic [NEXT+1:0]   mask,
    input  logic [NEXT-1:0]   ext_req,
    input  logic              m1,
    input  logic              iorq,
    output logic              n_int,
    output logic [7:0]        vector,
    output logic              vector_oe,
    output logic [NEXT+1:0]   pending,
    output logic [2:0]        active_ch
);
    localparam int unsigned NCH = NEXT + 2;

    typedef enum logic [1:0] {IDLE, ASSERT, ACK, GAP} state_t;

    state_t          state, state_d;
    logic [7:0]      cnt, cnt_d;
    logic            gap_cnt, gap_cnt_d;
    logic [2:0]      active_d, win;
    logic [NCH-1:0]  ev, req, sel, pend_clr;
    logic [7:0]      mask8;
    logic [8:0]      int_v, int_h;
    logic            frame_armed, line_armed, frame_ev, line_ev, ack, found;
    logic [NEXT-1:0] ext_s1, ext_s2, ext_prev;

    always_comb begin
        int_v = 9'(INT_V_S48);
        int_h = 9'(INT_H_S48);
        case (timings)
            S128: begin int_v = 9'(INT_V_S128); int_h = 9'(INT_H_S128); end
            PENT: begin int_v = 9'(INT_V_PENT); int_h = 9'(INT_H_PENT); end
            default: ;
        endcase
    end

    // hc >= INT_H rather than == so coarse hc stepping cannot skip the event
    assign frame_ev = frame_armed && (vc == int_v) && (hc >= int_h);
    assign line_ev  = line_armed && (vc == line_vc) && (hc >= int_h);
    assign ev       = {ext_s2 & ~ext_prev, line_ev, frame_ev};
    assign ack      = m1 & iorq;
    assign req      = pending & mask;
    assign mask8    = 8'(mask);

    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            frame_armed <= 1'b1;
            line_armed  <= 1'b1;
            ext_s1      <= '0;
            ext_s2      <= '0;
            ext_prev    <= '0;
            pending     <= '0;
        end else begin
            if (frame_ev)       frame_armed <= 1'b0;
            else if (vc == '0)  frame_armed <= 1'b1;
            if (line_ev)        line_armed  <= 1'b0;
            else if (hc < 9'd8) line_armed  <= 1'b1;
            ext_s1   <= ext_req;
            ext_s2   <= ext_s1;
            ext_prev <= ext_s2;
            // a new event wins over a same-edge clear
            pending  <= (pending & ~pend_clr) | ev;
        end
    end

    always_comb begin
        win   = '0;
        found = 1'b0;
        sel   = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (req[i] && !found) begin
                win   = 3'(i);
                found = 1'b1;
            end
            sel[i] = (active_ch == 3'(i));
        end

        state_d   = state;
        cnt_d     = cnt;
        gap_cnt_d = gap_cnt;
        active_d  = active_ch;
        pend_clr  = '0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_d  = ASSERT;
                    cnt_d    = '0;
                    active_d = win;
                end
            end
            ASSERT: begin
                cnt_d = cnt + 8'd1;
                if (ack) begin
                    state_d  = ACK;
                    pend_clr = sel;
                end else if (!mask8[active_ch]) begin
                    state_d   = GAP;
                    gap_cnt_d = 1'b0;
                end else if (active_ch == '0 && cnt == 8'(INT_LEN - 1)) begin
                    state_d   = GAP;
                    gap_cnt_d = 1'b0;
                    pend_clr  = sel;
                end
            end
            ACK: begin
                if (!iorq) begin
                    state_d   = GAP;
                    gap_cnt_d = 1'b0;
                end
            end
            GAP: begin
                if (gap_cnt) state_d   = IDLE;
                else         gap_cnt_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            gap_cnt   <= 1'b0;
            active_ch <= '0;
            n_int     <= 1'b1;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            gap_cnt   <= gap_cnt_d;
            active_ch <= active_d;
            n_int     <= (state_d != ASSERT);
        end
    end

    assign vector_oe = (state == ACK) & ack;
    assign vector    = (state == ACK) ? (VEC_BASE | {4'b0000, active_ch, 1'b0}) : VEC_BASE;

endmodule

// File: tb/tb_cpu_int_ctrl.sv
// Scoreboard bench for cpu_int_ctrl: stimulus queues the expected INT pulse
// outcome, a monitor checks each pulse as n_int returns high.
module tb_cpu_int_ctrl;
    import cpu_int_ctrl_pkg::*;

    logic       clkcpu = 1'b0;
    logic       rst_n;
    logic [8:0] vc, hc, line_vc;
    timings_t   timings;
    logic [3:0] mask;
    logic [1:0] ext_req;
    logic       m1, iorq;
    logic       n_int, vector_oe;
    logic [7:0] vector;
    logic [3:0] pending;
    logic [2:0] active_ch;

    cpu_int_ctrl #(.NEXT(2), .INT_LEN(32), .VEC_BASE(8'hE0)) dut (
        .rst_n(rst_n), .clkcpu(clkcpu), .vc(vc), .hc(hc), .timings(timings),
        .line_vc(line_vc), .mask(mask), .ext_req(ext_req), .m1(m1), .iorq(iorq),
        .n_int(n_int), .vector(vector), .vector_oe(vector_oe),
        .pending(pending), .active_ch(active_ch)
    );

    always #5 clkcpu = ~clkcpu;

    typedef struct {
        bit         ack;
        logic [7:0] vec;
        int         len;
    } exp_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input bit ack, input logic [7:0] vec, input int len);
        exp_t e;
        e.ack = ack;
        e.vec = vec;
        e.len = len;
        expq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clkcpu);
        #1;
    endtask

    task automatic wait_low(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (n_int === 1'b0) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL %s: n_int still high after %0d cycles, expected low", name, budget);
    endtask

    task automatic wait_high(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (n_int === 1'b1) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL %s: n_int still low after %0d cycles, expected high", name, budget);
    endtask

    task automatic ack_int();
        wait_low(100, "ack_wait");
        tick();
        m1 = 1'b1; iorq = 1'b1;
        tick();
        @(negedge clkcpu); #1;
        m1 = 1'b0; iorq = 1'b0;
        tick();
    endtask

    initial begin : monitor
        int   low_cnt;
        exp_t e;
        low_cnt = 0;
        forever begin
            @(negedge clkcpu);
            if (n_int === 1'b0) begin
                low_cnt++;
            end else if (low_cnt != 0) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got pulse of %0d cycles, expected none", low_cnt);
                end else begin
                    e = expq.pop_front();
                    chk("pulse_vector_oe", 32'(vector_oe), 32'(e.ack));
                    chk("pulse_vector", 32'(vector), 32'(e.vec));
                    if (e.len != 0) chk("pulse_len", low_cnt, e.len);
                end
                low_cnt = 0;
            end
        end
    end

    initial begin : stim
        int lows;
        rst_n = 1'b0; vc = 9'd100; hc = 9'd0; line_vc = 9'd300; timings = S48;
        mask = 4'b0000; ext_req = 2'b00; m1 = 1'b0; iorq = 1'b0;
        #12;
        chk("rst_n_int", 32'(n_int), 32'h1);
        chk("rst_vector_oe", 32'(vector_oe), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_active_ch", 32'(active_ch), 32'h0);
        chk("rst_vector", 32'(vector), 32'hE0);
        rst_n = 1'b1;
        repeat (2) tick();

        // frame INT with coarse hc steps, unacknowledged -> 32-cycle timeout
        mask = 4'b0001; vc = 9'd247;
        push(1'b0, 8'hE0, 32);
        for (int i = 0; i < 20; i++) begin
            hc = 9'(432 + 4 * i);
            tick();
        end
        wait_high(60, "t1_timeout");
        chk("t1_pending0_cleared", 32'(pending[0]), 32'h0);
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (n_int === 1'b0) lows++;
        end
        chk("t1_single_pulse", lows, 0);

        // frame INT acked on its 5th low cycle, then GAP length
        vc = 9'd0; tick();
        vc = 9'd247; hc = 9'd442;
        push(1'b1, 8'hE0, 5);
        wait_low(10, "t2_assert");
        ext_req[0] = 1'b1;
        repeat (4) tick();
        m1 = 1'b1; iorq = 1'b1;
        tick();
        chk("t2_ack_nint", 32'(n_int), 32'h1);
        chk("t2_ack_vector", 32'(vector), 32'hE0);
        chk("t2_ack_oe", 32'(vector_oe), 32'h1);
        m1 = 1'b0; #1;
        chk("t2_oe_tracks_m1_low", 32'(vector_oe), 32'h0);
        m1 = 1'b1; #1;
        chk("t2_oe_tracks_m1_high", 32'(vector_oe), 32'h1);
        @(negedge clkcpu); #1;
        mask = 4'b1111;
        push(1'b1, 8'hE4, 0);
        m1 = 1'b0; iorq = 1'b0;
        tick(); chk("t2_gap1", 32'(n_int), 32'h1);
        tick(); chk("t2_gap2", 32'(n_int), 32'h1);
        tick(); chk("t2_idle", 32'(n_int), 32'h1);
        tick(); chk("t2_reassert", 32'(n_int), 32'h0);
        ack_int();

        // line event and ext_req[1] in the same cycle
        vc = 9'd100; hc = 9'd0;
        repeat (4) tick();
        chk("t3_pre_pending", 32'(pending), 32'h0);
        line_vc = 9'd100; tick();
        ext_req[1] = 1'b1;
        tick(); tick();
        hc = 9'd450;
        tick();
        chk("t3_both_pending", 32'(pending), 32'hA);
        push(1'b1, 8'hE2, 0);
        push(1'b1, 8'hE6, 0);
        ack_int();
        ack_int();
        ext_req = 2'b00; line_vc = 9'd300; hc = 9'd0;
        repeat (4) tick();
        chk("t3_post_pending", 32'(pending), 32'h0);

        // new ext_req[0] edge on the same edge as its ack clear
        ext_req[0] = 1'b1;
        push(1'b1, 8'hE4, 0);
        wait_low(10, "t4_assert");
        tick();
        ext_req[0] = 1'b0;
        repeat (4) tick();
        ext_req[0] = 1'b1;
        tick(); tick();
        m1 = 1'b1; iorq = 1'b1;
        tick();
        chk("t4_acked", 32'(n_int), 32'h1);
        chk("t4_pending_kept", 32'(pending[2]), 32'h1);
        push(1'b1, 8'hE4, 0);
        @(negedge clkcpu); #1;
        m1 = 1'b0; iorq = 1'b0;
        tick();
        ack_int();
        repeat (3) tick();
        chk("t4_post_pending", 32'(pending), 32'h0);

        // asynchronous reset while in ACK
        ext_req[0] = 1'b0;
        repeat (4) tick();
        ext_req[0] = 1'b1;
        push(1'b1, 8'hE4, 0);
        wait_low(10, "t5_assert");
        tick();
        ext_req[0] = 1'b0;
        m1 = 1'b1; iorq = 1'b1;
        tick();
        chk("t5_in_ack_oe", 32'(vector_oe), 32'h1);
        @(negedge clkcpu); #2;
        rst_n = 1'b0; #1;
        chk("t5_rst_nint", 32'(n_int), 32'h1);
        chk("t5_rst_oe", 32'(vector_oe), 32'h0);
        chk("t5_rst_pending", 32'(pending), 32'h0);
        #1;
        m1 = 1'b0; iorq = 1'b0; rst_n = 1'b1;
        repeat (4) tick();
        chk("t5_after_reset", 32'(n_int), 32'h1);

        // mask drop during a line INT, then restore
        hc = 9'd0; line_vc = 9'd100; tick();
        hc = 9'd450;
        push(1'b0, 8'hE0, 0);
        wait_low(10, "t6_assert");
        tick(); tick();
        mask = 4'b1101;
        tick();
        chk("t6_mask_release", 32'(n_int), 32'h1);
        chk("t6_pending_kept", 32'(pending[1]), 32'h1);
        lows = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (n_int === 1'b0) lows++;
        end
        chk("t6_held_off", lows, 0);
        mask = 4'b1111;
        push(1'b1, 8'hE2, 0);
        ack_int();
        repeat (4) tick();
        chk("t6_post_pending", 32'(pending), 32'h0);

        repeat (5) tick();
        chk("queue_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_int_ctrl.md
CPU_INT_CTRL -- requirements
Module: cpu_int_ctrl

Interface
REQ-001 SHALL have parameter NEXT, default 2, number of external interrupt channels (1..6).
REQ-002 SHALL have parameter INT_LEN, default 32, frame-INT pulse length in clkcpu cycles (1..255).
REQ-003 SHALL have parameter VEC_BASE, default 8'hE0, IM2 vector base; low nibble SHALL be zero.
REQ-004 SHALL have parameters INT_V_S48/INT_H_S48, default 247/442; INT_V_S128/INT_H_S128, default 247/450; INT_V_PENT/INT_H_PENT, default 239/316.
REQ-005 SHALL have input rst_n, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have input clkcpu, 1 bit: CPU clock; all state on posedge.
REQ-007 SHALL have inputs vc and hc, 9 bits each: raster counters.
REQ-008 SHALL have input timings, timings_t: selects the frame INT position.
REQ-009 SHALL have input line_vc, 9 bits: line-interrupt raster line.
REQ-010 SHALL have input mask, NEXT+2 bits: per-channel enable, 1 = enabled.
REQ-011 SHALL have input ext_req, NEXT bits: external requests, rising-edge sensitive.
REQ-012 SHALL have inputs m1 and iorq, 1 bit each, active-high: CPU acknowledge cycle when both are 1.
REQ-013 SHALL have output n_int, 1 bit: active-low INT to CPU.
REQ-014 SHALL have output vector, 8 bits: IM2 vector.
REQ-015 SHALL have output vector_oe, 1 bit: drive vector onto the data bus.
REQ-016 SHALL have output pending, NEXT+2 bits: pending flags.
REQ-017 SHALL have output active_ch, 3 bits: index of the channel being serviced.

Function
REQ-018 Channels SHALL be: 0 = frame, 1 = line, 2..NEXT+1 = ext_req[0..NEXT-1]; the lowest index SHALL have highest priority.
REQ-019 Frame event SHALL fire once per frame on the first cycle with vc == INT_V and hc >= INT_H (per timings); an armed flag SHALL clear on the event and re-arm when vc == 0. Skipped hc values SHALL NOT lose the event.
REQ-020 Line event SHALL fire once per line when vc == line_vc and hc >= INT_H of the current timing, armed per line; it SHALL re-arm on hc < 8.
REQ-021 External events SHALL fire on a 0->1 edge of ext_req[i] sampled on clkcpu, using a 2-flop synchroniser plus an edge register.
REQ-022 An event SHALL set pending[ch] on the next edge regardless of mask; mask SHALL gate only the arbitration.
REQ-023 FSM states SHALL be IDLE, ASSERT, ACK, GAP.
REQ-024 IDLE -> ASSERT SHALL occur when (pending & mask) != 0; the winning channel SHALL be latched into active_ch and a 8-bit counter cleared; n_int SHALL be 0 from the next edge.
REQ-025 In ASSERT the counter SHALL increment each cycle.
REQ-026 In ASSERT, m1 & iorq SHALL move the FSM to ACK, set n_int = 1, and clear pending[active_ch].
REQ-027 In ASSERT with channel 0 and counter == INT_LEN-1 (no ack), the FSM SHALL go to GAP with n_int = 1 and pending[0] cleared (missed frame INT is dropped).
REQ-028 Channels >= 1 SHALL hold n_int low until acknowledged; no timeout.
REQ-029 In ACK, vector SHALL = VEC_BASE | (active_ch << 1) and vector_oe SHALL = m1 & iorq (combinational); iorq == 0 SHALL move the FSM to GAP.
REQ-030 GAP SHALL last exactly 2 cycles, then return to IDLE; this guarantees n_int is high for >= 2 cycles between requests.
REQ-031 If an event and a clear hit the same channel on the same edge, pending SHALL end set.
REQ-032 If mask[active_ch] drops during ASSERT, the FSM SHALL go to GAP, n_int SHALL = 1, and pending SHALL be kept.
REQ-033 vector SHALL be VEC_BASE whenever the FSM is not in ACK.

Reset
REQ-034 On rst_n = 0 the block SHALL immediately set: FSM = IDLE, n_int = 1, vector_oe = 0, pending = 0, active_ch = 0, counters = 0, synchronisers = 0, armed flags = 1.
REQ-035 Reset mid-ASSERT or mid-ACK SHALL release n_int and vector_oe asynchronously.

Verification
REQ-036 timings = S48, mask = 1, hc stepped by 4 past 442 at vc = 247 -> exactly one n_int low pulse of 32 cycles, pending[0] cleared at timeout.
REQ-037 Frame INT acked at cycle 5 with m1 = iorq = 1 -> n_int high next edge; vector = 8'hE0; vector_oe tracks m1 & iorq; GAP lasts 2 cycles.
REQ-038 ext_req[1] and line event in the same cycle, mask = all ones -> channel 1 serviced first (vector 8'hE2), then channel 3 (vector 8'hE6) after GAP.
REQ-039 ext_req[0] rises while pending[2] is being cleared by ack -> pending[2] stays 1 and is re-serviced.
REQ-040 rst_n asserted during ACK -> n_int = 1 and vector_oe = 0 with no clock edge; pending = 0.
REQ-041 mask[1] cleared during a line INT -> n_int = 1 within 1 cycle, pending[1] stays 1, and re-assert occurs when the mask is restored.
